ms6205_screen_rx: RTL and testbench

// - Display-side receiver of the MS6205 character-display bus driven by the emulator front panel.
// - Samples the active-low addr/data strobes and captures writes into a 16x10 character buffer.
// - Exposes a synchronous read port for a scan-out/video renderer.
// - Reports the marker (cursor) position.

---
 rtl/ms6205_pkg.sv | 33 +++
 rtl/ms6205_char_ram.sv | 33 +++
 rtl/ms6205_screen_rx.sv | 171 +++++++++++++++++
 tb/tb_ms6205_screen_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ms6205_pkg.sv
// Shared constants, types and helpers for the MS6205 character-display receiver.
package ms6205_pkg;

  localparam int unsigned COLUMNS   = 16;
  localparam int unsigned ROWS      = 10;
  localparam int unsigned MAX_POS   = COLUMNS * ROWS;
  localparam int unsigned POS_W     = 8;
  localparam int unsigned CHAR_W    = 7;
  localparam int unsigned BLINK_DIV = 500;

  localparam logic [POS_W-1:0]  MAX_POS_B  = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]  LAST_POS   = POS_W'(MAX_POS - 1);
  localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h20;
  localparam logic [POS_W-1:0]  NO_MARKER  = 8'hFF;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LATCHED
  } state_t;

  // One character-buffer write: target cell plus 7-bit character.
  typedef struct packed {
    logic [POS_W-1:0]  addr;
    logic [CHAR_W-1:0] chr;
  } wr_req_t;

  // Next screen position, wrapping the last cell back to 0.
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p >= LAST_POS) ? '0 : p + POS_W'(1);
  endfunction

endpackage

// File: rtl/ms6205_char_ram.sv
// 160x7 character buffer: one write port, one registered read port, read-before-write.
module ms6205_char_ram
  import ms6205_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  wr_req_t           wr,
  input  logic [POS_W-1:0]  rd_addr,
  output logic [CHAR_W-1:0] rd_data
);

  logic [CHAR_W-1:0] mem [MAX_POS];

  // Storage has no reset; the receiver's CLEAR pass initialises it.
  always_ff @(posedge clk) begin
    if (we && (wr.addr < MAX_POS_B)) begin
      mem[wr.addr] <= wr.chr;
    end
  end

  // Out-of-range reads return a blank so the renderer sees empty cells.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= CHAR_SPACE;
    end else if (rd_addr < MAX_POS_B) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= CHAR_SPACE;
    end
  end

endmodule

// File: rtl/ms6205_screen_rx.sv
// MS6205 display-bus receiver: strobe sync, write FSM, marker tracking, scan-out read.
// Optional blinking marker when MS6205_CURSOR_EN is defined.
module ms6205_screen_rx
  import ms6205_pkg::*;
#(
  parameter int unsigned SYNC_FF = 2
) (
  input  logic              Clock_1ms,
  input  logic              Rst,
  input  logic              ms6205_addr_acq,
  input  logic              ms6205_data_acq,
  input  logic [POS_W-1:0]  address,
  input  logic [7:0]        data,
  input  logic              marker,
  input  logic [POS_W-1:0]  rd_addr,
  output logic [CHAR_W-1:0] rd_char,
  output logic              rd_marker,
  output logic              busy,
  output logic              addr_err
);

  logic [SYNC_FF-1:0] addr_sync;
  logic [SYNC_FF-1:0] data_sync;
  logic               addr_prev;
  logic               data_prev;
  logic               addr_ev;
  logic               data_ev;
  logic               addr_ok;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [POS_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [POS_W-1:0]   marker_q, marker_d;
  logic               addr_err_d;
  logic               busy_d;
  logic               wr_en;
  wr_req_t            wr_req;
  logic               blink_phase;
  logic               unused_bits;

  assign unused_bits = data[7];

  // Strobe synchronizers plus one delay flop for fall detection; idle level is 1.
  always_ff @(posedge Clock_1ms) begin
    if (Rst) begin
      addr_sync <= '1;
      data_sync <= '1;
      addr_prev <= 1'b1;
      data_prev <= 1'b1;
    end else begin
      addr_sync <= {addr_sync[SYNC_FF-2:0], ms6205_addr_acq};
      data_sync <= {data_sync[SYNC_FF-2:0], ms6205_data_acq};
      addr_prev <= addr_sync[SYNC_FF-1];
      data_prev <= data_sync[SYNC_FF-1];
    end
  end

  assign addr_ev = addr_prev & ~addr_sync[SYNC_FF-1];
  assign data_ev = data_prev & ~data_sync[SYNC_FF-1];
  assign addr_ok = (address < MAX_POS_B);

  // State and control registers.
  always_ff @(posedge Clock_1ms) begin
    if (Rst) begin
      state_q   <= CLEAR;
      wr_ptr_q  <= '0;
      clr_ptr_q <= '0;
      marker_q  <= NO_MARKER;
      addr_err  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      clr_ptr_q <= clr_ptr_d;
      marker_q  <= marker_d;
      addr_err  <= addr_err_d;
      busy      <= busy_d;
    end
  end

  // Next-state, write request and bookkeeping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    clr_ptr_d   = clr_ptr_q;
    marker_d    = marker_q;
    addr_err_d  = addr_err;
    wr_en       = 1'b0;
    wr_req.addr = wr_ptr_q;
    wr_req.chr  = data[CHAR_W-1:0];

    case (state_q)
      CLEAR: begin
        wr_en       = 1'b1;
        wr_req.addr = clr_ptr_q;
        wr_req.chr  = CHAR_SPACE;
        if (clr_ptr_q == LAST_POS) begin
          clr_ptr_d = '0;
          state_d   = IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + POS_W'(1);
        end
      end

      default: begin
        if (addr_ev && !addr_ok) begin
          addr_err_d = 1'b1;
        end
        if (addr_ev && addr_ok) begin
          if (marker) begin
            marker_d = address;
          end
          state_d = LATCHED;
          // A data strobe landing with the address strobe writes the new cell.
          if (data_ev) begin
            wr_en       = 1'b1;
            wr_req.addr = address;
            wr_ptr_d    = pos_inc(address);
          end else begin
            wr_ptr_d = address;
          end
        end else if (data_ev && (state_q == LATCHED)) begin
          wr_en    = 1'b1;
          wr_ptr_d = pos_inc(wr_ptr_q);
        end
      end
    endcase

    busy_d = (state_d == CLEAR);
  end

`ifdef MS6205_CURSOR_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt;

  // Free-running half-period counter for the marker blink.
  always_ff @(posedge Clock_1ms) begin
    if (Rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end
`else
  always_comb blink_phase = 1'b1;
`endif

  // Marker flag aligned with the registered character read.
  always_ff @(posedge Clock_1ms) begin
    if (Rst) begin
      rd_marker <= 1'b0;
    end else begin
      rd_marker <= (marker_q != NO_MARKER) && (rd_addr == marker_q) && blink_phase;
    end
  end

  ms6205_char_ram u_ram (
    .clk     (Clock_1ms),
    .rst     (Rst),
    .we      (wr_en),
    .wr      (wr_req),
    .rd_addr (rd_addr),
    .rd_data (rd_char)
  );

endmodule

// File: tb/tb_ms6205_screen_rx.sv
// Self-checking bench for ms6205_screen_rx: directed cases then randomized bus traffic,
// reads checked by a scoreboard against a behavioural screen model.
module tb_ms6205_screen_rx;

  logic       Clock_1ms = 1'b0;
  logic       Rst = 1'b1;
  logic       addr_acq = 1'b1;
  logic       data_acq = 1'b1;
  logic [7:0] address = 8'd0;
  logic [7:0] data = 8'd0;
  logic       marker = 1'b0;
  logic [7:0] rd_addr = 8'd0;
  logic [6:0] rd_char;
  logic       rd_marker;
  logic       busy;
  logic       addr_err;

  always #5 Clock_1ms = ~Clock_1ms;

  ms6205_screen_rx dut (
    .Clock_1ms       (Clock_1ms),
    .Rst             (Rst),
    .ms6205_addr_acq (addr_acq),
    .ms6205_data_acq (data_acq),
    .address         (address),
    .data            (data),
    .marker          (marker),
    .rd_addr         (rd_addr),
    .rd_char         (rd_char),
    .rd_marker       (rd_marker),
    .busy            (busy),
    .addr_err        (addr_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference screen model.
  logic [6:0] m_mem [160];
  bit         m_latched;
  int         m_ptr;
  int         m_marker;
  bit         m_err;

  typedef struct {
    int         a;
    logic [6:0] ch;
    logic       mk;
  } exp_t;
  exp_t sb[$];

  bit rd_req = 1'b0;
  int cyc = 0;

  always @(posedge Clock_1ms) begin
    if (Rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit exp_phase();
`ifdef MS6205_CURSOR_EN
    return 1'b1 ^ bit'((cyc / 500) % 2);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 160; i++) m_mem[i] = 7'h20;
    m_latched = 1'b0;
    m_ptr     = 0;
    m_marker  = -1;
    m_err     = 1'b0;
  endtask

  // Reset for 'hold' cycles, check reset outputs, then measure busy length.
  task automatic do_reset(input int hold);
    int cnt;
    @(negedge Clock_1ms);
    Rst = 1'b1;
    repeat (hold) @(negedge Clock_1ms);
    check("reset rd_char", 32'(rd_char), 32'h20);
    check("reset rd_marker", 32'(rd_marker), 32'h0);
    check("reset busy", 32'(busy), 32'h1);
    check("reset addr_err", 32'(addr_err), 32'h0);
    Rst = 1'b0;
    model_reset();
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge Clock_1ms);
    end
    check("busy cycles", 32'(cnt), 32'd160);
  endtask

  // Drive one strobe pulse (address, data or both) and apply the bus rules to the model.
  task automatic strobe(input bit da, input bit dd, input logic [7:0] a,
                        input logic [7:0] d, input logic m);
    @(negedge Clock_1ms);
    address = a;
    data    = d;
    marker  = m;
    @(negedge Clock_1ms);
    addr_acq = ~da;
    data_acq = ~dd;
    repeat (5) @(negedge Clock_1ms);
    addr_acq = 1'b1;
    data_acq = 1'b1;
    repeat (5) @(negedge Clock_1ms);
    marker = 1'b0;
    if (da && a < 160) begin
      if (m) m_marker = int'(a);
      if (dd) begin
        m_mem[a] = d[6:0];
        m_ptr    = (int'(a) + 1) % 160;
      end else begin
        m_ptr = int'(a);
      end
      m_latched = 1'b1;
    end else begin
      if (da) m_err = 1'b1;
      if (dd && m_latched) begin
        m_mem[m_ptr] = d[6:0];
        m_ptr        = (m_ptr + 1) % 160;
      end
    end
  endtask

  task automatic rd(input int a);
    exp_t e;
    @(negedge Clock_1ms);
    rd_addr = 8'(a);
    rd_req  = 1'b1;
    e.a  = a;
    e.ch = (a < 160) ? m_mem[a] : 7'h20;
    e.mk = (m_marker >= 0 && a == m_marker) ? exp_phase() : 1'b0;
    sb.push_back(e);
    @(negedge Clock_1ms);
    rd_req = 1'b0;
  endtask

  // Monitor: each issued read presents its result one edge later.
  always @(posedge Clock_1ms) begin
    if (rd_req) begin
      exp_t e;
      #1;
      if (sb.size() == 0) begin
        check("scoreboard underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("rd_char[%0d]", e.a), 32'(rd_char), 32'(e.ch));
        check($sformatf("rd_marker[%0d]", e.a), 32'(rd_marker), 32'(e.mk));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int wait_cnt;
    logic [7:0] ra;

    do_reset(2);
    for (int i = 0; i < 160; i++) rd(i);

    // Sequential writes from address 5.
    strobe(1, 0, 8'd5, 8'h00, 1'b0);
    strobe(0, 1, 8'd0, 8'h41, 1'b0);
    strobe(0, 1, 8'd0, 8'hC2, 1'b0);
    rd(5); rd(6); rd(7);

    // Pointer wraps from the last cell to 0.
    strobe(1, 0, 8'd159, 8'h00, 1'b0);
    strobe(0, 1, 8'd0, 8'h58, 1'b0);
    strobe(0, 1, 8'd0, 8'h59, 1'b0);
    rd(159); rd(0);

    // Out-of-range address keeps the old pointer and sets the sticky error.
    strobe(1, 0, 8'd200, 8'h00, 1'b0);
    check("addr_err after 200", 32'(addr_err), 32'h1);
    strobe(0, 1, 8'd0, 8'h5A, 1'b0);
    rd(1); rd(200); rd(255);

    // Marker cell.
    strobe(1, 0, 8'd20, 8'h00, 1'b1);
    rd(19); rd(20); rd(21); rd(255);
    repeat (250) @(negedge Clock_1ms);
    rd(20);
    repeat (500) @(negedge Clock_1ms);
    rd(20);

    // Randomized bus traffic.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 3));
      ra   = 8'($urandom_range(0, 175));
      case (kind)
        0:       strobe(1, 0, ra, 8'($urandom), ($urandom_range(0, 7) == 0));
        1, 2:    strobe(0, 1, ra, 8'($urandom), 1'b0);
        default: strobe(1, 1, ra, 8'($urandom), ($urandom_range(0, 7) == 0));
      endcase
      check("addr_err random", 32'(addr_err), 32'(m_err));
      rd((m_ptr + 159) % 160);
      rd(int'($urandom_range(0, 255)));
    end

    // Fresh screen, then a simultaneous address+data write.
    do_reset(1);
    strobe(1, 1, 8'd7, 8'h51, 1'b0);
    rd(7); rd(8);

    // Reset while still clearing restarts the clear pass.
    @(negedge Clock_1ms);
    Rst = 1'b1;
    @(negedge Clock_1ms);
    Rst = 1'b0;
    repeat (50) @(negedge Clock_1ms);
    do_reset(1);
    rd(7); rd(8); rd(20); rd(159);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 100) begin
      wait_cnt++;
      @(negedge Clock_1ms);
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
